// File: rtl/order_tx_serializer_pkg.sv
// hft_tx_pkg: shared types and constants for the order transmit serializer.
//   - tx_state_e  : serializer FSM states (CSUM only reachable when
//                   ORDER_TX_CHECKSUM_EN is defined)
//   - NUM_WORDS   : words per order message (fixed by the core's register bank)
//   - IDX_WIDTH   : width of the word index inside a message
//   - order_msg_t : one whole message; word[0] carries reg_1
//   - msg_xor     : XOR of all words of a message (checksum beat)
package hft_tx_pkg;

  localparam int MSG_REG_WIDTH = 32;
  localparam int NUM_WORDS     = 7;
  localparam int IDX_WIDTH     = $clog2(NUM_WORDS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2
  } tx_state_e;

  typedef struct packed {
    logic [NUM_WORDS-1:0][MSG_REG_WIDTH-1:0] word;
  } order_msg_t;

  function automatic logic [MSG_REG_WIDTH-1:0] msg_xor(input order_msg_t msg);
    logic [MSG_REG_WIDTH-1:0] acc;
    acc = {MSG_REG_WIDTH{1'b0}};
    for (int i = 0; i < NUM_WORDS; i++) begin
      acc = acc ^ msg.word[i];
    end
    return acc;
  endfunction

endpackage

// File: rtl/order_tx_serializer_if.sv
// order_tx_if: 32-bit valid/ready stream link from the serializer to the MAC.
//   o_tdata  : stream word
//   o_tvalid : o_tdata is valid
//   o_tlast  : final word of a message
//   i_tready : downstream accepts the word when o_tvalid & i_tready
// Modports: master (serializer side), slave (sink side).
interface order_tx_if #(
  parameter int REG_WIDTH = 32
);
  logic [REG_WIDTH-1:0] o_tdata;
  logic                 o_tvalid;
  logic                 o_tlast;
  logic                 i_tready;

  modport master (output o_tdata, output o_tvalid, output o_tlast, input i_tready);
  modport slave  (input o_tdata, input o_tvalid, input o_tlast, output i_tready);
endinterface

// File: rtl/order_tx_serializer_fifo.sv
// order_tx_fifo: single-clock FIFO of whole order messages.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data (ignored when full unless pop is also high)
//   pop        : remove the head entry (pop_data shows it combinationally)
//   full/empty : occupancy flags
//   count      : entries currently stored
module order_tx_fifo
  import hft_tx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  order_msg_t             push_data,
  input  logic                   pop,
  output order_msg_t             pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  order_msg_t       mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign count     = count_r;
  assign pop_data  = mem_r[rd_ptr_r];
  assign pop_ok_s  = pop && !empty;
  // When full, the slot being freed by a simultaneous pop takes the new entry.
  assign push_ok_s = push && (!full || pop_ok_s);

  // Message storage; no reset needed since count_r gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/order_tx_serializer.sv
// order_tx_serializer: captures 7-word order messages on i_valid, buffers up
// to DEPTH of them and streams them word by word (reg_1 first) on tx.
//   i_clk, i_reset_n   : clock, asynchronous active-low reset
//   i_reg_1..i_reg_7   : message words, sampled when i_valid=1
//   i_valid            : one-cycle capture strobe
//   tx (master)        : o_tdata/o_tvalid/o_tlast out, i_tready in
//   o_msg_count        : buffered messages (message in flight excluded)
//   o_overflow         : sticky, a message was dropped on a full buffer
//   o_drop_count       : dropped messages, saturating at 255
// Optional feature: define ORDER_TX_CHECKSUM_EN to append an 8th beat holding
// the XOR of words 1..7; o_tlast then moves to that beat.
module order_tx_serializer
  import hft_tx_pkg::*;
#(
  parameter int REG_WIDTH = MSG_REG_WIDTH,
  parameter int DEPTH     = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic [REG_WIDTH-1:0]   i_reg_1,
  input  logic [REG_WIDTH-1:0]   i_reg_2,
  input  logic [REG_WIDTH-1:0]   i_reg_3,
  input  logic [REG_WIDTH-1:0]   i_reg_4,
  input  logic [REG_WIDTH-1:0]   i_reg_5,
  input  logic [REG_WIDTH-1:0]   i_reg_6,
  input  logic [REG_WIDTH-1:0]   i_reg_7,
  input  logic                   i_valid,
  order_tx_if.master             tx,
  output logic [$clog2(DEPTH):0] o_msg_count,
  output logic                   o_overflow,
  output logic [7:0]             o_drop_count
);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_WORDS - 1);

  tx_state_e            state_r, state_n;
  logic [IDX_WIDTH-1:0] idx_r, idx_n;
  order_msg_t           hold_r, hold_n;
  order_msg_t           in_msg_s, head_s;
  logic                 pop_s, fifo_full_s, fifo_empty_s, drop_s;
  logic [REG_WIDTH-1:0] tdata_r, tdata_n;
  logic                 tvalid_r, tvalid_n, tlast_r, tlast_n;
  logic                 overflow_r;
  logic [7:0]           drop_cnt_r;

  assign in_msg_s.word = {i_reg_7, i_reg_6, i_reg_5, i_reg_4, i_reg_3, i_reg_2, i_reg_1};
  assign drop_s        = i_valid && fifo_full_s && !pop_s;

  order_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_reset_n),
    .push      (i_valid),
    .push_data (in_msg_s),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (o_msg_count)
  );

  // Next-state logic: load the next message whenever the link is free or the
  // final beat is accepted, so consecutive messages stream without a bubble.
  always_comb begin
    state_n = state_r;
    idx_n   = idx_r;
    hold_n  = hold_r;
    pop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          hold_n  = head_s;
          idx_n   = {IDX_WIDTH{1'b0}};
          state_n = SEND;
        end else begin
          state_n = IDLE;
        end
      end
      SEND: begin
        if (tx.i_tready) begin
          if (idx_r == LAST_IDX) begin
`ifdef ORDER_TX_CHECKSUM_EN
            state_n = CSUM;
`else
            if (!fifo_empty_s) begin
              pop_s   = 1'b1;
              hold_n  = head_s;
              idx_n   = {IDX_WIDTH{1'b0}};
              state_n = SEND;
            end else begin
              state_n = IDLE;
            end
`endif
          end else begin
            idx_n = idx_r + IDX_WIDTH'(1);
          end
        end else begin
          state_n = SEND;
        end
      end
`ifdef ORDER_TX_CHECKSUM_EN
      CSUM: begin
        if (tx.i_tready) begin
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            hold_n  = head_s;
            idx_n   = {IDX_WIDTH{1'b0}};
            state_n = SEND;
          end else begin
            state_n = IDLE;
          end
        end else begin
          state_n = CSUM;
        end
      end
`endif
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Stream outputs are computed from the next state so they can be registered
  // and still appear in the same cycle the FSM enters that state.
  always_comb begin
    tvalid_n = 1'b0;
    tlast_n  = 1'b0;
    tdata_n  = {REG_WIDTH{1'b0}};
    case (state_n)
      SEND: begin
        tvalid_n = 1'b1;
        tdata_n  = hold_n.word[idx_n];
`ifdef ORDER_TX_CHECKSUM_EN
        tlast_n  = 1'b0;
`else
        tlast_n  = (idx_n == LAST_IDX);
`endif
      end
`ifdef ORDER_TX_CHECKSUM_EN
      CSUM: begin
        tvalid_n = 1'b1;
        tdata_n  = msg_xor(hold_n);
        tlast_n  = 1'b1;
      end
`endif
      default: begin
        tvalid_n = 1'b0;
        tlast_n  = 1'b0;
        tdata_n  = {REG_WIDTH{1'b0}};
      end
    endcase
  end

  // FSM, holding register and registered stream outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r  <= IDLE;
      idx_r    <= {IDX_WIDTH{1'b0}};
      hold_r   <= {$bits(order_msg_t){1'b0}};
      tdata_r  <= {REG_WIDTH{1'b0}};
      tvalid_r <= 1'b0;
      tlast_r  <= 1'b0;
    end else begin
      state_r  <= state_n;
      idx_r    <= idx_n;
      hold_r   <= hold_n;
      tdata_r  <= tdata_n;
      tvalid_r <= tvalid_n;
      tlast_r  <= tlast_n;
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= 8'd0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      if (drop_cnt_r != 8'hFF) drop_cnt_r <= drop_cnt_r + 8'd1;
    end
  end

  assign tx.o_tdata   = tdata_r;
  assign tx.o_tvalid  = tvalid_r;
  assign tx.o_tlast   = tlast_r;
  assign o_overflow   = overflow_r;
  assign o_drop_count = drop_cnt_r;
endmodule

// File: tb/tb_order_tx_serializer.sv
// Self-checking bench for order_tx_serializer: a driver applies directed and
// random stimulus and runs a message-level reference model; a monitor on the
// falling edge compares link beats against a scoreboard queue and the status
// outputs against the model.
module tb_order_tx_serializer;
  import hft_tx_pkg::*;

  localparam int W     = 32;
  localparam int DEPTH = 4;
`ifdef ORDER_TX_CHECKSUM_EN
  localparam int BEATS = 8;
`else
  localparam int BEATS = 7;
`endif

  typedef logic [6:0][W-1:0] msg_t;
  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  logic                   clk   = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   valid = 1'b0;
  logic [W-1:0]           regs [7];
  logic [$clog2(DEPTH):0] msg_count;
  logic                   overflow;
  logic [7:0]             drop_count;

  order_tx_if #(.REG_WIDTH(W)) tx_bus ();

  order_tx_serializer #(.REG_WIDTH(W), .DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_reg_1      (regs[0]),
    .i_reg_2      (regs[1]),
    .i_reg_3      (regs[2]),
    .i_reg_4      (regs[3]),
    .i_reg_5      (regs[4]),
    .i_reg_6      (regs[5]),
    .i_reg_7      (regs[6]),
    .i_valid      (valid),
    .tx           (tx_bus.master),
    .o_msg_count  (msg_count),
    .o_overflow   (overflow),
    .o_drop_count (drop_count)
  );

  always #5 clk = ~clk;

  // Reference model state: messages buffered, in-flight message beats left.
  int    m_cnt   = 0;
  bit    m_busy  = 1'b0;
  int    m_left  = 0;
  bit    m_ovf   = 1'b0;
  int    m_drops = 0;
  beat_t exp_q[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Expected link beats for one accepted message, in transmit order.
  function automatic void expect_msg(input msg_t m);
    beat_t b;
    logic [W-1:0] x;
    x = '0;
    for (int i = 0; i < 7; i++) begin
      b.data = m[i];
      b.last = (i == 6) && (BEATS == 7);
      exp_q.push_back(b);
      x = x ^ m[i];
    end
`ifdef ORDER_TX_CHECKSUM_EN
    b.data = x;
    b.last = 1'b1;
    exp_q.push_back(b);
`endif
  endfunction

  function automatic void model_clear();
    m_cnt = 0; m_busy = 1'b0; m_left = 0; m_ovf = 1'b0; m_drops = 0;
    exp_q.delete();
  endfunction

  // One clock edge of the behavioural model, using the inputs of that cycle.
  function automatic void model_edge();
    bit   pop;
    int   cnt_pre;
    msg_t m;
    if (!rst_n) return;
    cnt_pre = m_cnt;
    pop = (m_cnt > 0) && (!m_busy || (tx_bus.i_tready && m_left == 1));
    if (m_busy && tx_bus.i_tready) m_left--;
    if (pop) begin
      m_cnt--;
      m_busy = 1'b1;
      m_left = BEATS;
    end else if (m_left == 0) begin
      m_busy = 1'b0;
    end
    if (valid) begin
      if (cnt_pre < DEPTH || pop) begin
        for (int i = 0; i < 7; i++) m[i] = regs[i];
        m_cnt++;
        expect_msg(m);
      end else begin
        m_ovf = 1'b1;
        if (m_drops < 255) m_drops++;
      end
    end
  endfunction

  // Apply inputs for one cycle, advance the model at the edge, settle 1 unit.
  task automatic tick(input bit v, input msg_t m, input bit rdy);
    valid = v;
    for (int i = 0; i < 7; i++) regs[i] = m[i];
    tx_bus.i_tready = rdy;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic msg_t rand_msg();
    msg_t m;
    for (int i = 0; i < 7; i++) m[i] = $urandom();
    return m;
  endfunction

  // Monitor: compare every cycle away from the active edge.
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_data;
  logic         prev_last;
  always @(negedge clk) begin
    beat_t e;
    chk("tvalid", W'(tx_bus.o_tvalid), W'(m_busy));
    chk("msg_count", W'(msg_count), W'(m_cnt));
    chk("overflow", W'(overflow), W'(m_ovf));
    chk("drop_count", W'(drop_count), W'(m_drops));
    if (!tx_bus.o_tvalid) chk("tdata_idle_zero", tx_bus.o_tdata, '0);
    if (prev_stall && rst_n) begin
      chk("stall_tvalid", W'(tx_bus.o_tvalid), W'(1));
      chk("stall_tdata", tx_bus.o_tdata, prev_data);
      chk("stall_tlast", W'(tx_bus.o_tlast), W'(prev_last));
    end
    if (tx_bus.o_tvalid && tx_bus.i_tready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", tx_bus.o_tdata, '0);
        chk("unexpected_beat_flag", W'(1), W'(exp_q.size()));
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", tx_bus.o_tdata, e.data);
        chk("beat_last", W'(tx_bus.o_tlast), W'(e.last));
      end
    end
    prev_stall = rst_n && tx_bus.o_tvalid && !tx_bus.i_tready;
    prev_data  = tx_bus.o_tdata;
    prev_last  = tx_bus.o_tlast;
  end

  initial begin
    msg_t ma, mc, zero;
    int   guard;
    zero = '0;
    for (int i = 0; i < 7; i++) begin
      regs[i] = '0;
      ma[i]   = W'((i + 1) * 'h11);
      mc[i]   = W'(1) << i;
    end
    tx_bus.i_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single message, always ready.
    tick(1'b1, ma, 1'b1);
    repeat (12) tick(1'b0, zero, 1'b1);

    // Backpressure for 3 cycles while the third word is presented.
    tick(1'b1, ma, 1'b1);
    tick(1'b0, zero, 1'b1);
    tick(1'b0, zero, 1'b1);
    tick(1'b0, zero, 1'b1);
    repeat (3) tick(1'b0, zero, 1'b0);
    repeat (12) tick(1'b0, zero, 1'b1);

    // One-hot words: checksum beat would be 0x7F.
    tick(1'b1, mc, 1'b1);
    repeat (12) tick(1'b0, zero, 1'b1);

    // Three consecutive strobes stream back to back.
    repeat (3) tick(1'b1, rand_msg(), 1'b1);
    repeat (28) tick(1'b0, zero, 1'b1);

    // Overflow: six strobes with the link stalled.
    repeat (6) tick(1'b1, rand_msg(), 1'b0);
    repeat (3) tick(1'b0, zero, 1'b0);
    repeat (50) tick(1'b0, zero, 1'b1);

    // Reset while word 4 of a message is on the link, 2 more buffered.
    repeat (3) tick(1'b1, rand_msg(), 1'b1);
    guard = 0;
    while (!(m_busy && m_left == BEATS - 3) && guard < 20) begin
      tick(1'b0, zero, 1'b1);
      guard++;
    end
    chk("reach_word4_bound", W'(guard < 20), W'(1));
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(1'b1, ma, 1'b1);
    repeat (12) tick(1'b0, zero, 1'b1);

    // Random traffic and random backpressure.
    for (int n = 0; n < 1500; n++) begin
      tick($urandom_range(0, 99) < 25, rand_msg(), $urandom_range(0, 99) < 70);
    end
    repeat (60) tick(1'b0, zero, 1'b1);

    // Drop counter saturation.
    repeat (270) tick(1'b1, rand_msg(), 1'b0);
    repeat (60) tick(1'b0, zero, 1'b1);

    chk("scoreboard_drained", W'(exp_q.size()), W'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
